// File: rtl/i2s_pkg.sv
// i2s_pkg: shared state encoding, I2S format constants and default geometry
// for the WM8731-style clock-master interface.
package i2s_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic LRC_LEFT     = 1'b0;
    localparam int   DATA_DELAY   = 1;
    localparam int   DEF_BCLK_DIV = 8;
    localparam int   DEF_SLOTS    = 32;
    localparam int   DEF_SAMPLE_W = 16;

endpackage

// File: rtl/i2s_codec_master_bclk_gen.sv
// i2s_bclk_gen: BCLK divider; rise/fall strobe on the cycle whose closing edge
// moves the BCLK register 0->1 / 1->0.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic clk50M,
    input  logic reset_n,
    input  logic clear,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int DW = $clog2(BCLK_DIV);

    logic [DW-1:0] div_cnt;
    logic          tc;

    always_comb begin
        tc   = !clear && int'(div_cnt) == BCLK_DIV - 1;
        rise = tc && !bclk;
        fall = tc && bclk;
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (clear) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else begin
            div_cnt <= tc ? '0 : div_cnt + DW'(1);
            bclk    <= bclk ^ tc;
        end
    end

endmodule

// File: rtl/i2s_codec_master.sv
// i2s_codec_master: I2S clock master that serializes a latched stereo pair onto
// ADCDAT and deserializes DACDAT into rx_left/rx_right once per frame.
module i2s_codec_master
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = DEF_BCLK_DIV,
    parameter int SLOTS    = DEF_SLOTS,
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic                clk50M,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] tx_left,
    input  logic [SAMPLE_W-1:0] tx_right,
    output logic                tx_req,
    output logic [SAMPLE_W-1:0] rx_left,
    output logic [SAMPLE_W-1:0] rx_right,
    output logic                rx_valid,
    output logic                BCLK,
    output logic                DACLRC,
    output logic                ADCLRC,
    output logic                ADCDAT,
    input  logic                DACDAT
);

    localparam int BW = $clog2(2 * SLOTS);

    state_t              state, state_nx;
    logic [BW-1:0]       bit_cnt, nb;
    logic [SAMPLE_W-1:0] sh_l, sh_r, rs_l, rs_r, tx_sel;
    logic [1:0]          sync;
    logic                lrc, cap, rise, fall, run, load, adc_nx, shift;
    int                  pn, pr;

    i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .clk50M (clk50M),
        .reset_n(reset_n),
        .clear  (!run),
        .bclk   (BCLK),
        .rise   (rise),
        .fall   (fall)
    );

    assign DACLRC = lrc;
    assign ADCLRC = lrc;

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // pn: slot position after the pending fall; pr: slot position during the current bit
    always_comb begin
        state_nx = enable ? RUN : IDLE;
        run      = state == RUN && enable;
        nb       = int'(bit_cnt) == 2 * SLOTS - 1 ? '0 : bit_cnt + BW'(1);
        pn       = int'(nb) % SLOTS;
        pr       = int'(bit_cnt) % SLOTS;
        load     = (state == IDLE && enable) || (fall && nb == '0);
        tx_sel   = (int'(nb) < SLOTS ? sh_l : sh_r) >> (SAMPLE_W - 1 - pn + DATA_DELAY);
        adc_nx   = pn >= DATA_DELAY && pn < DATA_DELAY + SAMPLE_W && tx_sel[0];
        shift    = rise && pr >= DATA_DELAY && pr < DATA_DELAY + SAMPLE_W;
    end

    // cap marks the last data rise of the right half; the copy happens one cycle
    // later so the final shifted-in bit is already in rs_r
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            sh_l     <= '0;
            sh_r     <= '0;
            rs_l     <= '0;
            rs_r     <= '0;
            rx_left  <= '0;
            rx_right <= '0;
            bit_cnt  <= '0;
            sync     <= '0;
            lrc      <= 1'b0;
            ADCDAT   <= 1'b0;
            cap      <= 1'b0;
            tx_req   <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            sync     <= {sync[0], DACDAT};
            tx_req   <= load;
            cap      <= rise && int'(bit_cnt) == SLOTS + DATA_DELAY + SAMPLE_W - 1;
            rx_valid <= run && cap;
            if (load) begin
                sh_l <= tx_left;
                sh_r <= tx_right;
            end
            if (!run) begin
                bit_cnt <= '0;
                lrc     <= 1'b0;
                ADCDAT  <= 1'b0;
            end else if (fall) begin
                bit_cnt <= nb;
                lrc     <= int'(nb) >= SLOTS ? ~LRC_LEFT : LRC_LEFT;
                ADCDAT  <= adc_nx;
            end
            if (shift && int'(bit_cnt) < SLOTS)  rs_l <= {rs_l[SAMPLE_W-2:0], sync[1]};
            if (shift && int'(bit_cnt) >= SLOTS) rs_r <= {rs_r[SAMPLE_W-2:0], sync[1]};
            if (run && cap) begin
                rx_left  <= rs_l;
                rx_right <= rs_r;
            end
        end
    end

endmodule

// File: tb/tb_i2s_codec_master.sv
// tb_i2s_codec_master: loopback bench for the I2S master with a frame vector
// table, a receive scoreboard and hand-written abort/reset sequences.
module tb_i2s_codec_master;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        inv;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    logic        clk = 0, reset_n = 1, enable = 0, inv = 0;
    logic [15:0] tx_left = 0, tx_right = 0, last_el = 0, last_er = 0;
    logic [15:0] rx_left, rx_right;
    logic        tx_req, rx_valid, BCLK, DACLRC, ADCLRC, ADCDAT, DACDAT;
    logic [31:0] sb[$];
    vec_t        vec[7];
    int          n_cmp = 0, n_err = 0, bad = 0;

    always #10 clk = ~clk;

    // loopback, optionally inverted so received data differs from sent data
    assign DACDAT = ADCDAT ^ inv;

    i2s_codec_master dut (
        .clk50M  (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tx_left (tx_left),
        .tx_right(tx_right),
        .tx_req  (tx_req),
        .rx_left (rx_left),
        .rx_right(rx_right),
        .rx_valid(rx_valid),
        .BCLK    (BCLK),
        .DACLRC  (DACLRC),
        .ADCLRC  (ADCLRC),
        .ADCDAT  (ADCDAT),
        .DACDAT  (DACDAT)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int r);
        logic [15:0] t;
        t = 16'h0;
        if (r >= 1 && r <= 16) t = v.l >> (16 - r);
        else if (r >= 33 && r <= 48) t = v.r >> (48 - r);
        return t[0];
    endfunction

    // one full frame starting at the negedge where tx_req is expected
    task automatic run_frame(input vec_t v, input vec_t nxt);
        int          r, nreq, nval;
        logic        pb;
        logic [31:0] e;
        r = 0;
        nreq = 0;
        nval = 0;
        pb = 0;
        for (int c = 0; c < 1024; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("tx_req_frame_start", tx_req, 1);
                inv = v.inv;
                sb.push_back({v.el, v.er});
            end else if (tx_req) nreq++;
            if (c == 300) begin
                tx_left  = nxt.l;
                tx_right = nxt.r;
            end
            if (c == 700) begin
                check("rx_left_hold", rx_left, last_el);
                check("rx_right_hold", rx_right, last_er);
            end
            if (BCLK && !pb) begin
                check("bclk_rise_time", c, 8 + 16 * r);
                check("adcdat_bit", ADCDAT, exp_bit(v, r));
                check("lrc_level", {DACLRC, ADCLRC}, r >= 32 ? 2'b11 : 2'b00);
                r++;
            end
            pb = BCLK;
            if (rx_valid) begin
                nval++;
                check("rx_valid_time", c, 777);
                check("sb_depth", sb.size(), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rx_left", rx_left, e[31:16]);
                    check("rx_right", rx_right, e[15:0]);
                    last_el = e[31:16];
                    last_er = e[15:0];
                end
            end
        end
        check("bclk_rises", r, 64);
        check("extra_tx_req", nreq, 0);
        check("rx_valid_count", nval, 1);
    endtask

    initial begin
        vec[0] = '{16'hA5C3, 16'h0001, 1'b0, 16'hA5C3, 16'h0001};
        vec[1] = '{16'h7FFF, 16'h8000, 1'b0, 16'h7FFF, 16'h8000};
        vec[2] = '{16'h1234, 16'hFEDC, 1'b1, 16'hEDCB, 16'h0123};
        vec[3] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000};
        vec[4] = '{16'h5555, 16'hFFFF, 1'b0, 16'hFFFF, 16'h0000};
        vec[5] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'h0F0F, 16'hF0F0};
        vec[6] = '{16'hC3A5, 16'h8001, 1'b1, 16'h3C5A, 16'h7FFE};

        #3 reset_n = 0;
        repeat (4) @(negedge clk);
        check("reset_ctl", {tx_req, rx_valid, BCLK, DACLRC, ADCLRC, ADCDAT}, 0);
        check("reset_rx", {rx_left, rx_right}, 0);
        tx_left  = vec[0].l;
        tx_right = vec[0].r;
        reset_n  = 1;
        enable   = 1;
        for (int i = 0; i < 4; i++) run_frame(vec[i], vec[i + 1]);

        // abort mid right half, then restart
        for (int c = 0; c <= 600; c++) begin
            @(negedge clk);
            if (c == 0) check("abort_frame_req", tx_req, 1);
        end
        check("pre_abort_levels", {BCLK, DACLRC, ADCLRC, ADCDAT}, 4'hF);
        enable = 0;
        @(negedge clk);
        check("abort_outputs", {BCLK, DACLRC, ADCLRC, ADCDAT, tx_req, rx_valid}, 0);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_req || rx_valid || BCLK || DACLRC || ADCDAT) bad++;
        end
        check("idle_quiet", bad, 0);
        check("abort_rx_left", rx_left, vec[4].el);
        check("abort_rx_right", rx_right, vec[4].er);
        tx_left  = vec[5].l;
        tx_right = vec[5].r;
        enable   = 1;
        run_frame(vec[5], vec[6]);

        // asynchronous reset mid-frame
        for (int c = 0; c <= 408; c++) begin
            @(negedge clk);
            if (c == 0) check("reset_frame_req", tx_req, 1);
        end
        check("pre_reset_bclk", BCLK, 1);
        #2 reset_n = 0;
        #1;
        check("async_reset_ctl", {tx_req, rx_valid, BCLK, DACLRC, ADCLRC, ADCDAT}, 0);
        check("async_reset_rx", {rx_left, rx_right}, 0);
        last_el = 0;
        last_er = 0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx_req || rx_valid || BCLK) bad++;
        end
        check("reset_quiet", bad, 0);
        tx_left  = vec[6].l;
        tx_right = vec[6].r;
        reset_n  = 1;
        run_frame(vec[6], vec[0]);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
